uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver: the downstream partner of the 8N1 UART transmitter on the same link.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_receiver_if.sv | 23 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_receiver.sv | 150 +++++++++++++++
 tb/tb_uart_receiver.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, used by both link directions.
package uart_pkg;

  // 100 MHz system clock at 9600 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 10416;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side bundle of the UART receiver: received byte, valid/ack holding
// handshake, error pulses and the busy indicator.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ack;
  logic                 framing_error;
  logic                 overrun;
  logic                 busy;

  // The receiver drives the byte and status; the consumer answers with ack.
  modport master (
    output data, data_valid, framing_error, overrun, busy,
    input  data_ack
  );

  modport slave (
    input  data, data_valid, framing_error, overrun, busy,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset to
// the idle-high level so that reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops; the second one is the only copy the FSM may use.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: validates the start bit at half a bit period, samples the
// data and stop bits at mid-bit, and hands each good byte to the consumer
// through a valid/ack holding register. Bad stop bits and unread bytes that
// get overwritten are reported as single-cycle pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RxD,
  uart_receiver_if.master rx
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bitidx_q, bitidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_i  (RxD),
    .rx_o  (rx_s)
  );

  // State, counters, shift register and the consumer-facing holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Frame sequencing and handshake; a good stop bit takes priority over an ack
  // in the same cycle so the new byte is never lost.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    if (rx.data_ack && valid_q) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d  = RX_DATA;
            bitidx_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
          bitidx_d = bitidx_q + 1'b1;
          if (bitidx_q == IDX_LAST) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = RX_IDLE;
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx.data_ack;
          end else begin
            state_d = RX_BREAK;
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_BREAK: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx.data          = data_q;
  assign rx.data_valid    = valid_q;
  assign rx.framing_error = ferr_q;
  assign rx.overrun       = ovr_q;
  assign rx.busy          = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed-plus-random bench for the UART receiver at a short bit period.
// Frames are built bit by bit from the byte value; expected bytes, flags and
// arrival times come from the serial framing rules, not from the receiver's
// internal structure.
module tb_uart_receiver;

  localparam int CPB     = 16;
  localparam int HALF    = CPB / 2;
  localparam int LAT_NOM = 2 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic RxD;

  uart_receiver_if rxIf ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .RxD   (RxD),
    .rx    (rxIf)
  );

  // 100 MHz-style clock; period is arbitrary for this bench.
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running cycle counter used to time-stamp frame starts and byte arrivals.
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Observed events, sampled on the falling edge away from DUT updates.
  logic       validPrev = 1'b0;
  logic       busyPrev  = 1'b0;
  int         riseCount = 0;
  int         feCount   = 0;
  int         ovCount   = 0;
  int         busyRises = 0;
  logic [7:0] gotBytes[$];
  int         riseCycles[$];

  // Record every valid rise with its byte and time, and count flag pulses.
  always @(negedge clk) begin
    if (rxIf.data_valid && !validPrev) begin
      riseCount++;
      gotBytes.push_back(rxIf.data);
      riseCycles.push_back(cycleCnt);
    end
    if (rxIf.framing_error) feCount++;
    if (rxIf.overrun) ovCount++;
    if (rxIf.busy && !busyPrev) busyRises++;
    validPrev = rxIf.data_valid;
    busyPrev  = rxIf.busy;
  end

  // Consumer: either acks every held byte automatically, or raises ack for
  // exactly one chosen cycle.
  logic autoAck = 1'b0;
  int   coAckAt = -1;
  initial begin
    rxIf.data_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cycleCnt == coAckAt)
        rxIf.data_ack = 1'b1;
      else if (autoAck && rxIf.data_valid && !rxIf.data_ack)
        rxIf.data_ack = 1'b1;
      else
        rxIf.data_ack = 1'b0;
    end
  end

  // Hard stop in case something never finishes.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame starting on the current falling edge; returns the cycle stamp of the start bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, output int startCyc);
    logic [9:0] bits;
    bits     = {stopBit, b, 1'b0};
    startCyc = cycleCnt;
    for (int i = 0; i < 10; i++) begin
      RxD = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  int         st;
  int         st2;
  int         lat;
  int         baseRise;
  int         baseFe;
  int         baseOv;
  int         baseBusy;
  logic [7:0] seq[6];
  logic [7:0] b1, b2, b3, b4, rec;

  initial begin
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset_data", rxIf.data, 8'h00);
    checkOutput("reset_valid", rxIf.data_valid, 1'b0);
    checkOutput("reset_ferr", rxIf.framing_error, 1'b0);
    checkOutput("reset_ovr", rxIf.overrun, 1'b0);
    checkOutput("reset_busy", rxIf.busy, 1'b0);

    // Single frame 0xA5, left unacknowledged to inspect the holding register.
    baseRise = riseCount; baseFe = feCount; baseOv = ovCount;
    applyStimulus(8'hA5, 1'b1, st);
    repeat (8) @(negedge clk);
    checkOutput("t1_rises", riseCount - baseRise, 1);
    checkOutput("t1_data", rxIf.data, 8'hA5);
    checkOutput("t1_valid", rxIf.data_valid, 1'b1);
    lat = riseCycles[riseCycles.size() - 1] - st;
    checkOutput("t1_latency_in_window", (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1), 1'b1);
    checkOutput("t1_ferr_pulses", feCount - baseFe, 0);
    checkOutput("t1_ovr_pulses", ovCount - baseOv, 0);
    autoAck = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t1_valid_after_ack", rxIf.data_valid, 1'b0);

    // Back-to-back frames, each acknowledged: three fixed patterns then random bytes.
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    for (int i = 3; i < 6; i++) seq[i] = 8'($urandom_range(255));
    baseRise = riseCount; baseFe = feCount; baseOv = ovCount;
    for (int i = 0; i < 6; i++) applyStimulus(seq[i], 1'b1, st);
    repeat (8) @(negedge clk);
    checkOutput("t2_rises", riseCount - baseRise, 6);
    for (int i = 0; i < 6; i++) begin
      if (baseRise + i < gotBytes.size())
        checkOutput($sformatf("t2_byte%0d", i), gotBytes[baseRise + i], seq[i]);
      else
        checkOutput($sformatf("t2_byte%0d_missing", i), 1'b0, 1'b1);
    end
    checkOutput("t2_ferr_pulses", feCount - baseFe, 0);
    checkOutput("t2_ovr_pulses", ovCount - baseOv, 0);
    checkOutput("t2_valid_end", rxIf.data_valid, 1'b0);

    // Short low glitch: start bit fails validation.
    baseRise = riseCount; baseBusy = busyRises;
    RxD = 1'b0;
    repeat (5) @(negedge clk);
    RxD = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("t3_busy_pulses", busyRises - baseBusy, 1);
    checkOutput("t3_busy_end", rxIf.busy, 1'b0);
    checkOutput("t3_rises", riseCount - baseRise, 0);
    checkOutput("t3_valid", rxIf.data_valid, 1'b0);

    // Bad stop bit with the line then held low: one error, byte keeps the last good value.
    baseRise = riseCount; baseFe = feCount;
    applyStimulus(8'h3C, 1'b0, st);
    baseBusy = busyRises;
    repeat (40) @(negedge clk);
    checkOutput("t4_ferr_pulses", feCount - baseFe, 1);
    checkOutput("t4_data_kept", rxIf.data, seq[5]);
    checkOutput("t4_busy_held_low", rxIf.busy, 1'b1);
    checkOutput("t4_no_restart", busyRises - baseBusy, 0);
    RxD = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("t4_busy_released", rxIf.busy, 1'b0);
    checkOutput("t4_rises", riseCount - baseRise, 0);
    rec = 8'($urandom_range(255));
    applyStimulus(rec, 1'b1, st);
    repeat (8) @(negedge clk);
    checkOutput("t4_recovery_byte", gotBytes[gotBytes.size() - 1], rec);
    checkOutput("t4_recovery_rises", riseCount - baseRise, 1);

    // Two frames without ack: second byte overwrites and overrun fires once.
    autoAck = 1'b0;
    b1 = 8'($urandom_range(255));
    b2 = ~b1;
    baseRise = riseCount; baseOv = ovCount;
    applyStimulus(b1, 1'b1, st);
    applyStimulus(b2, 1'b1, st2);
    repeat (8) @(negedge clk);
    checkOutput("t5_data", rxIf.data, b2);
    checkOutput("t5_valid", rxIf.data_valid, 1'b1);
    checkOutput("t5_ovr_pulses", ovCount - baseOv, 1);
    checkOutput("t5_rises", riseCount - baseRise, 1);
    autoAck = 1'b1;
    repeat (4) @(negedge clk);
    autoAck = 1'b0;
    checkOutput("t5_valid_acked", rxIf.data_valid, 1'b0);

    // Same again, but ack lands on the cycle the second stop bit is accepted.
    // That cycle is the nominal latency plus the one cycle IDLE needs to see the
    // synchronised start edge, so ack is raised on the falling edge just before it.
    b3 = 8'($urandom_range(255));
    b4 = b3 ^ 8'h5A;
    baseOv = ovCount;
    applyStimulus(b3, 1'b1, st);
    coAckAt = cycleCnt + LAT_NOM;
    applyStimulus(b4, 1'b1, st2);
    repeat (8) @(negedge clk);
    coAckAt = -1;
    checkOutput("t5b_ovr_pulses", ovCount - baseOv, 0);
    checkOutput("t5b_data", rxIf.data, b4);
    checkOutput("t5b_valid", rxIf.data_valid, 1'b1);
    autoAck = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of the data bits, then a clean 0x81 frame.
    baseRise = riseCount; baseFe = feCount; baseOv = ovCount;
    RxD = 1'b0;
    repeat (HALF + 4 * CPB) @(negedge clk);
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6_busy_after_reset", rxIf.busy, 1'b0);
    checkOutput("t6_valid_after_reset", rxIf.data_valid, 1'b0);
    checkOutput("t6_data_after_reset", rxIf.data, 8'h00);
    autoAck = 1'b0;
    applyStimulus(8'h81, 1'b1, st);
    repeat (8) @(negedge clk);
    checkOutput("t6_data", rxIf.data, 8'h81);
    checkOutput("t6_valid", rxIf.data_valid, 1'b1);
    checkOutput("t6_rises", riseCount - baseRise, 1);
    checkOutput("t6_flags", (feCount - baseFe) + (ovCount - baseOv), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
